// File: rtl/sha_avalon_read_master_if.sv
// Avalon-MM read bus plus the outbound word stream of the SHA block fetcher.
// The master modport is the fetcher's view; slave is the memory/SHA-core side.
interface sha_avalon_read_master_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output avm_address, avm_read, out_data, out_valid,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, out_ready
  );

  modport slave (
    input  avm_address, avm_read, out_data, out_valid,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, out_ready
  );
endinterface

// File: rtl/sha_avalon_read_master.sv
// Pipelined Avalon-MM block reader feeding the SHA core through a credit-limited FIFO.
// Define SHA_RD_BYTESWAP_EN to byte-reverse each word as it enters the FIFO.
module sha_avalon_read_master #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [CNT_W-1:0]    word_count,
  output logic                busy,
  output logic                done,
  sha_avalon_read_master_if.master bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  received_q, received_d;
  logic [LvlW-1:0]   outstanding_q, outstanding_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic        accept, push, pop, credit_ok;
  logic [LvlW:0] inflight;
  logic [31:0] push_data;

`ifdef SHA_RD_BYTESWAP_EN
  assign push_data = {bus.avm_readdata[7:0], bus.avm_readdata[15:8],
                      bus.avm_readdata[23:16], bus.avm_readdata[31:24]};
`else
  assign push_data = bus.avm_readdata;
`endif

  always_comb begin
    accept = read_q && !bus.avm_waitrequest;
    // Responses arriving while idle belong to an aborted fetch and are dropped.
    push   = bus.avm_readdatavalid && (state_q != StIdle);
    pop    = (level_q != '0) && bus.out_ready;

    state_d       = state_q;
    addr_d        = addr_q;
    read_d        = read_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    count_d       = count_q;
    issued_d      = issued_q + CNT_W'(accept);
    received_d    = received_q + CNT_W'(push);
    outstanding_d = outstanding_q + LvlW'(accept) - LvlW'(push);
    level_d       = level_q + LvlW'(push) - LvlW'(pop);
    wr_ptr_d      = wr_ptr_q + PtrW'(push);
    rd_ptr_d      = rd_ptr_q + PtrW'(pop);

    // Credit uses next-cycle occupancy so a registered read can never overflow the FIFO.
    inflight  = {1'b0, outstanding_d} + {1'b0, level_d};
    credit_ok = inflight < (LvlW + 1)'(FIFO_DEPTH);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (word_count != '0) begin
            addr_d     = start_addr & ~ADDR_W'(3);
            count_d    = word_count;
            issued_d   = '0;
            received_d = '0;
            busy_d     = 1'b1;
            read_d     = 1'b1;
            state_d    = StIssue;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (accept) addr_d = addr_q + ADDR_W'(4);
        if (read_q && bus.avm_waitrequest) begin
          read_d = 1'b1;
        end else if (issued_d == count_q) begin
          read_d  = 1'b0;
          state_d = StDrain;
        end else begin
          read_d = credit_ok;
        end
      end
      StDrain: begin
        if (received_d == count_q && level_d == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      read_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      count_q       <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      level_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      read_q        <= read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      count_q       <= count_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      level_q       <= level_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign bus.avm_address = addr_q;
  assign bus.avm_read    = read_q;
  assign bus.out_valid   = (level_q != '0);
  assign bus.out_data    = (level_q != '0) ? mem_q[rd_ptr_q] : 32'h0;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_sha_avalon_read_master.sv
// Self-checking bench: Avalon slave model with fixed read latency and scoreboarded output stream.
module tb_sha_avalon_read_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] word_count;
  logic        busy, done;

  sha_avalon_read_master_if #(.ADDR_W(32)) bif ();

  sha_avalon_read_master #(
    .FIFO_DEPTH(8),
    .ADDR_W    (32),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .bus       (bif)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Slave model and scoreboard state.
  logic [31:0] sb [$];
  int          pend_due [$];
  logic [31:0] pend_dat [$];
  int          acc_cyc [$];
  logic [31:0] exp_addr = '0;
  logic [31:0] fixed_val = '0;
  logic [31:0] last_out = '0;
  logic        fixed_en = 1'b0;
  int          lat = 2;
  int          stall_left = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          rd_hi = 0;
  int          pops = 0;
  int          done_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gen_data(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hA5C3_1E0F;
  endfunction

  function automatic logic [31:0] model_out(input logic [31:0] d);
`ifdef SHA_RD_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    acc_cnt  = 0;
    rd_hi    = 0;
    pops     = 0;
    done_cnt = 0;
    acc_cyc.delete();
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] c);
    start      = 1'b1;
    start_addr = a;
    word_count = c;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int base;
    int n;
    base = done_cnt;
    n    = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(done_cnt != base), 32'd1);
  endtask

  // Slave + monitor: decides inputs for the coming posedge and samples outputs mid-cycle.
  initial begin
    logic [31:0] d;
    logic        ok;
    bif.avm_waitrequest   = 1'b0;
    bif.avm_readdatavalid = 1'b0;
    bif.avm_readdata      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bif.avm_read && stall_left > 0) begin
        bif.avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        bif.avm_waitrequest = 1'b0;
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bif.avm_readdatavalid = 1'b1;
        bif.avm_readdata      = pend_dat.pop_front();
        void'(pend_due.pop_front());
      end else begin
        bif.avm_readdatavalid = 1'b0;
      end
      if (!reset) begin
        if (bif.avm_read) begin
          rd_hi++;
          check_eq("avm_address", bif.avm_address, exp_addr);
        end
        if (bif.avm_read && !bif.avm_waitrequest) begin
          acc_cnt++;
          acc_cyc.push_back(cyc);
          d = fixed_en ? fixed_val : gen_data(bif.avm_address);
          pend_due.push_back(cyc + lat);
          pend_dat.push_back(d);
          sb.push_back(model_out(d));
          exp_addr = exp_addr + 32'd4;
        end
        if (bif.out_valid && bif.out_ready) begin
          ok = (sb.size() != 0);
          check_eq("pop_expected", 32'(ok), 32'd1);
          if (ok) check_eq("out_data", bif.out_data, sb.pop_front());
          last_out = bif.out_data;
          pops++;
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset         = 1'b1;
    start         = 1'b0;
    start_addr    = '0;
    word_count    = '0;
    bif.out_ready = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_read", 32'(bif.avm_read), 32'd0);
    check_eq("rst_addr", bif.avm_address, 32'd0);
    check_eq("rst_valid", 32'(bif.out_valid), 32'd0);
    check_eq("rst_data", bif.out_data, 32'd0);
    reset = 1'b0;
    tick();

    // Basic 4-word block, back-to-back issue.
    clr_stats();
    exp_addr = 32'h1000;
    do_start(32'h1000, 16'd4);
    check_eq("t1_latency_read", 32'(bif.avm_read), 32'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_done(60, "t1_done_seen");
    check_eq("t1_accepts", 32'(acc_cnt), 32'd4);
    check_eq("t1_span", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[0]), 32'd3);
    check_eq("t1_pops", 32'(pops), 32'd4);
    check_eq("t1_busy_after", 32'(busy), 32'd0);
    repeat (3) tick();
    check_eq("t1_done_once", 32'(done_cnt), 32'd1);

    // Unaligned address with a 3-cycle stall on the first read.
    clr_stats();
    exp_addr   = 32'h2000;
    stall_left = 3;
    do_start(32'h2003, 16'd2);
    wait_done(60, "t2_done_seen");
    check_eq("t2_accepts", 32'(acc_cnt), 32'd2);
    check_eq("t2_read_hi_cycles", 32'(rd_hi), 32'd5);
    check_eq("t2_pops", 32'(pops), 32'd2);

    // Stalled consumer: credit caps in-flight plus buffered words at the FIFO depth.
    clr_stats();
    bif.out_ready = 1'b0;
    exp_addr      = 32'h4000;
    do_start(32'h4000, 16'd20);
    repeat (40) tick();
    check_eq("t3_accepts_capped", 32'(acc_cnt), 32'd8);
    check_eq("t3_read_low", 32'(bif.avm_read), 32'd0);
    check_eq("t3_valid", 32'(bif.out_valid), 32'd1);
    check_eq("t3_head", bif.out_data, sb[0]);
    tick();
    check_eq("t3_head_stable", bif.out_data, sb[0]);
    bif.out_ready = 1'b1;
    wait_done(300, "t3_done_seen");
    check_eq("t3_accepts", 32'(acc_cnt), 32'd20);
    check_eq("t3_pops", 32'(pops), 32'd20);
    check_eq("t3_sb_empty", 32'(sb.size()), 32'd0);

    // Zero-length request, then a start issued while busy.
    clr_stats();
    do_start(32'h0, 16'd0);
    check_eq("t4_done_pulse", 32'(done), 32'd1);
    check_eq("t4_busy_low", 32'(busy), 32'd0);
    check_eq("t4_no_read", 32'(bif.avm_read), 32'd0);
    tick();
    check_eq("t4_done_clear", 32'(done), 32'd0);
    check_eq("t4_no_accepts", 32'(acc_cnt), 32'd0);
    clr_stats();
    exp_addr = 32'h5000;
    do_start(32'h5000, 16'd4);
    do_start(32'h6000, 16'd4);
    wait_done(60, "t4_done_seen");
    repeat (5) tick();
    check_eq("t4_accepts", 32'(acc_cnt), 32'd4);
    check_eq("t4_done_once", 32'(done_cnt), 32'd1);

    // Reset mid-fetch after three accepts; late responses must be dropped.
    clr_stats();
    lat      = 4;
    exp_addr = 32'h7000;
    do_start(32'h7000, 16'd10);
    n = 0;
    while (acc_cnt < 3 && n < 40) begin
      tick();
      n++;
    end
    check_eq("t5_three_accepts", 32'(acc_cnt), 32'd3);
    reset = 1'b1;
    tick();
    check_eq("t5_read_cleared", 32'(bif.avm_read), 32'd0);
    check_eq("t5_valid_cleared", 32'(bif.out_valid), 32'd0);
    check_eq("t5_busy_cleared", 32'(busy), 32'd0);
    reset = 1'b0;
    sb.delete();
    n = 0;
    while (pend_due.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check_eq("t5_late_dropped", 32'(bif.out_valid), 32'd0);
    check_eq("t5_no_done", 32'(done_cnt), 32'd0);
    clr_stats();
    lat      = 2;
    exp_addr = 32'h3000;
    do_start(32'h3000, 16'd1);
    wait_done(40, "t5_restart_done");
    check_eq("t5_restart_pops", 32'(pops), 32'd1);

    // Byte order of a known word.
    clr_stats();
    fixed_en  = 1'b1;
    fixed_val = 32'h1122_3344;
    exp_addr  = 32'h8000;
    do_start(32'h8000, 16'd1);
    wait_done(40, "t6_done_seen");
`ifdef SHA_RD_BYTESWAP_EN
    check_eq("t6_byte_order", last_out, 32'h4433_2211);
`else
    check_eq("t6_byte_order", last_out, 32'h1122_3344);
`endif
    fixed_en = 1'b0;

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_avalon_read_master.md
Name: sha_avalon_read_master

Overview:
- Avalon-MM pipelined read master that fetches a block of 32-bit words from SDRAM/on-chip memory for the SHA datapath.
- Software writes the block base address to the SHA address PIO output and pulses start; this block is the memory-side consumer of that address.
- Issues word reads starting at the latched address and buffers responses in an internal FIFO.
- Presents the words to the SHA core over a valid/ready stream.

Parameters:
- FIFO_DEPTH, 8, response FIFO entries; power of two, >= 2; also the limit on reads in flight.
- ADDR_W, 32, Avalon byte-address width.
- CNT_W, 16, width of word_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to begin a block fetch.
- start_addr  in  ADDR_W  block base byte address; bits [1:0] ignored and forced to 0.
- word_count  in  CNT_W  number of 32-bit words to fetch.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the block has been fully delivered.
- avm_address  out  ADDR_W  read byte address.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  response valid (pipelined, in order).
- out_data  out  32  word to the SHA core.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  SHA core accepts the word.

Behaviour:
- Reset values: busy=0, done=0, avm_read=0, avm_address=0, out_valid=0, out_data=0. FIFO is empty; all counters are 0; state is IDLE.
- FSM states are IDLE, ISSUE, DRAIN.
- IDLE:
  - start with word_count!=0 latches the address (addr[1:0]=0) and the count, sets busy, and moves to ISSUE.
  - start with word_count==0 pulses done on the next cycle; busy stays 0; state stays IDLE.
- ISSUE:
  - avm_read is raised only when issued<count and (outstanding+fifo_level) < FIFO_DEPTH.
  - Once raised, avm_read and avm_address are held stable until avm_waitrequest==0, regardless of credit.
  - Acceptance is a cycle with avm_read && !avm_waitrequest. On acceptance: address += 4 (wraps modulo 2^ADDR_W), issued++, outstanding++.
  - avm_read deasserts in the cycle after the final acceptance; the FSM then moves to DRAIN.
  - Back-to-back accepts are allowed: one read per cycle when credit exists and waitrequest is low.
- Latency: start sampled in cycle N gives avm_read=1 in cycle N+1.
- Response path: avm_readdatavalid pushes avm_readdata into the FIFO and decrements outstanding. The credit rule guarantees the FIFO never overflows.
- Simultaneous acceptance and response in one cycle: outstanding is unchanged.
- Output stream:
  - out_valid = FIFO not empty; out_data = FIFO head (first-word fall-through).
  - A pop occurs on out_valid && out_ready. out_data stays stable while out_valid && !out_ready.
  - A push and a pop in the same cycle leave the FIFO level unchanged. A push to an empty FIFO appears on out_valid the next cycle.
- DRAIN: when received==count and the FIFO is empty (last word popped), pulse done for 1 cycle, clear busy, and return to IDLE. A new start is accepted in the cycle after done.
- start while busy is ignored; latched address and count do not change.
- Synchronous reset mid-operation:
  - Aborts the fetch, flushes the FIFO, and returns to IDLE.
  - Clears avm_read immediately, with no wait on waitrequest; the interconnect shares the same reset.
  - No done pulse.
- avm_readdatavalid received in IDLE is discarded.
- Bubbles and backpressure: the throttle is based on FIFO level plus outstanding reads. A stalled consumer stops issuing after FIFO_DEPTH words are in flight or buffered.

Optional Feature:
- Macro: SHA_RD_BYTESWAP_EN.
- Defined: each word is byte-reversed on FIFO push ({d[7:0],d[15:8],d[23:16],d[31:24]}). This presents big-endian message words to the SHA core from the little-endian Nios memory.
- Undefined: avm_readdata passes through unchanged.
- Timing and handshakes are identical in both cases.

Test Plan:
- start_addr=0x1000, word_count=4, waitrequest=0, readdatavalid 2 cycles after each accept, out_ready=1 -> avm_address 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles. Four words emerge in order; done pulses once; busy low afterward.
- start_addr=0x2003, count=2, waitrequest high for 3 cycles on the first read -> avm_address=0x2000 held stable with avm_read=1 through the stall, then 0x2004. Exactly 2 accepts.
- FIFO_DEPTH=8, count=20, out_ready=0 -> exactly 8 reads accepted, then avm_read stays 0. Setting out_ready=1 resumes issuing. All 20 words arrive in order with no loss; no overflow.
- word_count=0 with start -> done=1 the next cycle; no avm_read; busy stays 0. A second start while busy with count=4 is ignored.
- reset asserted after 3 of 10 reads accepted -> avm_read=0, out_valid=0, busy=0 the next cycle; no done. A late readdatavalid is dropped. A new start (0x3000, 1) completes normally.
- SHA_RD_BYTESWAP_EN defined, readdata=0x11223344 -> out_data=0x44332211. Undefined -> out_data=0x11223344.
